// File: rtl/jt900h_intseq_pkg.sv
// Shared types and constants for the TLCS-900H interrupt entry sequencer.
// State encodings, bus access size codes and the default vector table base.
package jt900h_intseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH_PC = 2'd1,
        ST_PUSH_SR = 2'd2,
        ST_VEC_RD  = 2'd3
    } state_t;

    // Size codes are laid out as {ws, qs} so they can drive the bus flags directly.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_LONG = 2'b01,
        SZ_WORD = 2'b10
    } bus_size_t;

    localparam logic [23:0] VEC_BASE_DEF = 24'hFFFF00;
    localparam logic [2:0]  LVL_NMI      = 3'd7;

    function automatic logic [23:0] vec_entry(input logic [23:0] base, input logic [7:0] vec);
        return base | {16'd0, vec[7:2], 2'b00};
    endfunction

endpackage

// File: rtl/jt900h_intseq.sv
// Interrupt entry sequencer: accepts a request at an instruction boundary, pushes PC and SR
// through XSP, raises IFF and loads PC from the vector table while holding the core with busy.
module jt900h_intseq
    import jt900h_intseq_pkg::*;
#(
    parameter logic [23:0] VEC_BASE  = VEC_BASE_DEF,
    parameter logic [2:0]  IMASK_CAP = 3'd7
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [2:0]  int_lvl,
    input  logic [7:0]  int_vec,
    input  logic        inst_end,
    input  logic [2:0]  imask,
    input  logic [23:0] pc,
    input  logic [15:0] sr,
    input  logic [31:0] xsp,
    output logic        busy,
    output logic        int_ack,
    output logic [2:0]  ack_lvl,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_ws,
    output logic        bus_qs,
    output logic [23:0] bus_addr,
    output logic [31:0] bus_dout,
    input  logic        bus_ack,
    input  logic [31:0] bus_din,
    output logic        xsp_we,
    output logic [31:0] xsp_nx,
    output logic        pc_we,
    output logic [23:0] pc_nx,
    output logic        iff_we,
    output logic [2:0]  iff_nx
);

    state_t      st;
    logic [7:0]  vec_l;
    logic [15:0] sr_l;
    logic [31:0] xsp_l;

    logic        accept;
    logic        acked;
    logic [31:0] xsp_m4;
    logic [31:0] xsp_m6;
    logic [3:0]  iff_inc;
    logic [2:0]  iff_capped;
    logic        unused_din;

    // Level 7 is non-maskable and wins even when imask is already 7.
    assign accept = inst_end && (int_lvl != 3'd0) && ((int_lvl == LVL_NMI) || (int_lvl > imask));
    assign acked  = bus_req && bus_ack;

    assign xsp_m4 = xsp_l - 32'd4;
    assign xsp_m6 = xsp_l - 32'd6;

    assign iff_inc    = {1'b0, ack_lvl} + 4'd1;
    assign iff_capped = (iff_inc > {1'b0, IMASK_CAP}) ? IMASK_CAP : iff_inc[2:0];

    assign unused_din = ^bus_din[31:24];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_IDLE;
            vec_l    <= 8'd0;
            sr_l     <= 16'd0;
            xsp_l    <= 32'd0;
            busy     <= 1'b0;
            int_ack  <= 1'b0;
            ack_lvl  <= 3'd0;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            bus_ws   <= 1'b0;
            bus_qs   <= 1'b0;
            bus_addr <= 24'd0;
            bus_dout <= 32'd0;
            xsp_we   <= 1'b0;
            xsp_nx   <= 32'd0;
            pc_we    <= 1'b0;
            pc_nx    <= 24'd0;
            iff_we   <= 1'b0;
            iff_nx   <= 3'd0;
        end else if (cen) begin
            int_ack <= 1'b0;
            xsp_we  <= 1'b0;
            pc_we   <= 1'b0;
            iff_we  <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (accept) begin
                        vec_l              <= int_vec;
                        sr_l               <= sr;
                        xsp_l              <= xsp;
                        ack_lvl            <= int_lvl;
                        int_ack            <= 1'b1;
                        busy               <= 1'b1;
                        bus_req            <= 1'b1;
                        bus_we             <= 1'b1;
                        {bus_ws, bus_qs}   <= SZ_LONG;
                        bus_addr           <= xsp[23:0] - 24'd4;
                        bus_dout           <= {8'd0, pc};
                        st                 <= ST_PUSH_PC;
                    end
                end
                ST_PUSH_PC: begin
                    if (acked) begin
                        xsp_we           <= 1'b1;
                        xsp_nx           <= xsp_m4;
                        {bus_ws, bus_qs} <= SZ_WORD;
                        bus_addr         <= xsp_m6[23:0];
                        bus_dout         <= {16'd0, sr_l};
                        st               <= ST_PUSH_SR;
                    end
                end
                ST_PUSH_SR: begin
                    if (acked) begin
                        xsp_we           <= 1'b1;
                        xsp_nx           <= xsp_m6;
                        iff_we           <= 1'b1;
                        iff_nx           <= iff_capped;
                        bus_we           <= 1'b0;
                        {bus_ws, bus_qs} <= SZ_LONG;
                        bus_addr         <= vec_entry(VEC_BASE, vec_l);
                        bus_dout         <= 32'd0;
                        st               <= ST_VEC_RD;
                    end
                end
                ST_VEC_RD: begin
                    if (acked) begin
                        pc_we            <= 1'b1;
                        pc_nx            <= bus_din[23:0];
                        busy             <= 1'b0;
                        ack_lvl          <= 3'd0;
                        bus_req          <= 1'b0;
                        bus_we           <= 1'b0;
                        {bus_ws, bus_qs} <= SZ_BYTE;
                        bus_addr         <= 24'd0;
                        st               <= ST_IDLE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule
